// File: rtl/tl_write_back_pipelined.sv
`default_nettype none
// tl_write_back_pipelined -- MEM/WB stage register, load extension, write-back mux, retire counter. Rev 1.0
module tl_write_back_pipelined #(
  parameter int len                  = 32,
  parameter int NB_CTRL_WB           = 3,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_LOAD_TYPE         = 3,
  parameter int NB_COUNT             = 32
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_valid,
  input  logic                            i_stall,
  input  logic                            i_flush,
  input  logic [len-1:0]                  i_read_data,
  input  logic [len-1:0]                  i_result_alu,
  input  logic [len-1:0]                  i_return_addr,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_LOAD_TYPE-1:0]         i_load_type,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  output logic [len-1:0]                  o_write_data,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic                            o_RegWrite,
  output logic [NB_COUNT-1:0]             o_retired
);

  localparam logic [NB_LOAD_TYPE-1:0] LT_LH  = NB_LOAD_TYPE'(1);
  localparam logic [NB_LOAD_TYPE-1:0] LT_LHU = NB_LOAD_TYPE'(2);
  localparam logic [NB_LOAD_TYPE-1:0] LT_LB  = NB_LOAD_TYPE'(3);
  localparam logic [NB_LOAD_TYPE-1:0] LT_LBU = NB_LOAD_TYPE'(4);
  localparam logic [NB_ADDRESS_REGISTROS-1:0] LINK_REG = NB_ADDRESS_REGISTROS'(31);
  localparam logic [NB_COUNT-1:0] COUNT_ONE = NB_COUNT'(1);

  logic                            valid_q;
  logic [len-1:0]                  read_data_q;
  logic [len-1:0]                  result_alu_q;
  logic [len-1:0]                  return_addr_q;
  logic [NB_CTRL_WB-1:0]           ctrl_wb_q;
  logic [NB_LOAD_TYPE-1:0]         load_type_q;
  logic [NB_ADDRESS_REGISTROS-1:0] write_reg_q;
  logic [NB_COUNT-1:0]             retired_q;

  logic [7:0]                      byte_sel;
  logic [15:0]                     half_sel;
  logic [len-1:0]                  load_data;
  logic [len-1:0]                  wb_data;
  logic [NB_ADDRESS_REGISTROS-1:0] dest_reg;

  // Flush takes priority over stall so a squashed instruction never lingers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q       <= 1'b0;
      read_data_q   <= '0;
      result_alu_q  <= '0;
      return_addr_q <= '0;
      ctrl_wb_q     <= '0;
      load_type_q   <= '0;
      write_reg_q   <= '0;
      retired_q     <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (!i_stall) begin
      valid_q       <= i_valid;
      read_data_q   <= i_read_data;
      result_alu_q  <= i_result_alu;
      return_addr_q <= i_return_addr;
      ctrl_wb_q     <= i_ctrl_wb;
      load_type_q   <= i_load_type;
      write_reg_q   <= i_write_reg;
      if (i_valid) begin
        retired_q <= retired_q + COUNT_ONE;
      end
    end
  end

  always_comb begin
    case (result_alu_q[1:0])
      2'd0:    byte_sel = read_data_q[7:0];
      2'd1:    byte_sel = read_data_q[15:8];
      2'd2:    byte_sel = read_data_q[23:16];
      default: byte_sel = read_data_q[31:24];
    endcase
    half_sel = result_alu_q[1] ? read_data_q[31:16] : read_data_q[15:0];
    case (load_type_q)
      LT_LH:   load_data = {{(len-16){half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {{(len-16){1'b0}}, half_sel};
      LT_LB:   load_data = {{(len-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {{(len-8){1'b0}}, byte_sel};
      default: load_data = read_data_q;
    endcase
  end

  always_comb begin
    if (ctrl_wb_q[2]) begin
      wb_data = return_addr_q;
    end else if (ctrl_wb_q[1]) begin
      wb_data = load_data;
    end else begin
      wb_data = result_alu_q;
    end
    dest_reg = ctrl_wb_q[2] ? LINK_REG : write_reg_q;
  end

  assign o_write_data = valid_q ? wb_data : '0;
  assign o_write_reg  = valid_q ? dest_reg : '0;
  assign o_RegWrite   = valid_q & ctrl_wb_q[0] & (|dest_reg);
  assign o_retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_tl_write_back_pipelined.sv
`default_nettype none
// tb_tl_write_back_pipelined -- scoreboard bench for the write-back stage (NB_COUNT=4 to reach wrap).
module tb_tl_write_back_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, stall, flush;
  logic [31:0] read_data, result_alu, return_addr;
  logic [2:0]  ctrl_wb, load_type;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  write_reg_out;
  logic        reg_write;
  logic [3:0]  retired;

  always #5 clk = ~clk;

  tl_write_back_pipelined #(
    .len(32), .NB_CTRL_WB(3), .NB_ADDRESS_REGISTROS(5), .NB_LOAD_TYPE(3), .NB_COUNT(4)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_read_data(read_data), .i_result_alu(result_alu), .i_return_addr(return_addr),
    .i_ctrl_wb(ctrl_wb), .i_load_type(load_type), .i_write_reg(write_reg),
    .o_write_data(write_data), .o_write_reg(write_reg_out), .o_RegWrite(reg_write),
    .o_retired(retired)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  wr;
    logic        rw;
    logic [3:0]  ret;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  exp_t e;
  logic [3:0] ret_model;
  int total = 0;
  int bad = 0;

  // Drives one cycle, advances the stage model, queues the expected outputs.
  task automatic drive_one(input logic v, input logic st, input logic fl, input logic [2:0] c,
                           input logic [2:0] lt, input logic [31:0] rd, input logic [31:0] alu,
                           input logic [31:0] ra, input logic [4:0] wr, input logic [31:0] d);
    exp_t x;
    valid = v; stall = st; flush = fl; ctrl_wb = c; load_type = lt;
    read_data = rd; result_alu = alu; return_addr = ra; write_reg = wr;
    if (fl) begin
      held = '0;
    end else if (!st) begin
      if (v) begin
        held.data = d;
        held.wr   = c[2] ? 5'd31 : wr;
        held.rw   = c[0] && (held.wr != 5'd0);
        ret_model = ret_model + 4'd1;
      end else begin
        held = '0;
      end
    end
    x = held;
    x.ret = ret_model;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; stall = 0; flush = 0; ctrl_wb = 0; load_type = 0;
    read_data = 0; result_alu = 0; return_addr = 0; write_reg = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    held = '0; ret_model = 4'd0;
    valid = 1; stall = 0; flush = 0; ctrl_wb = 3'b001; load_type = 0;
    read_data = 32'h1234; result_alu = 32'h5678; return_addr = 32'h9abc; write_reg = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    total += 4;
    if (write_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", write_data); end
    if (write_reg_out !== 5'd0) begin bad++; $display("FAIL reset_reg got=%0d exp=0", write_reg_out); end
    if (reg_write !== 1'b0) begin bad++; $display("FAIL reset_rw got=%b exp=0", reg_write); end
    if (retired !== 4'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_rtype();
    drive_one(1, 0, 0, 3'b001, 3'd3, 32'hFFFF_FFFF, 32'h0000_0110, 32'h0, 5'd8, 32'h0000_0110);
    e = sb.pop_front();
    total += 5;
    if (write_data !== e.data) begin bad++; $display("FAIL rtype_data got=%h exp=%h", write_data, e.data); end
    if (write_reg_out !== e.wr) begin bad++; $display("FAIL rtype_reg got=%0d exp=%0d", write_reg_out, e.wr); end
    if (reg_write !== e.rw) begin bad++; $display("FAIL rtype_rw got=%b exp=%b", reg_write, e.rw); end
    if (retired !== e.ret) begin bad++; $display("FAIL rtype_retired got=%0d exp=%0d", retired, e.ret); end
    if (retired !== 4'd1) begin bad++; $display("FAIL rtype_first_count got=%0d exp=1", retired); end
  endtask

  task automatic test_loads();
    logic [2:0]  lts [10] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3, 3'd1, 3'd4, 3'd7, 3'd2};
    logic [31:0] alus[10] = '{32'h1000_0002, 32'h1000_0003, 32'h1000_0000, 32'h1000_0002, 32'h1000_0001,
                              32'h1000_0001, 32'h1000_0003, 32'h1000_0000, 32'h1000_0002, 32'h1000_0001};
    logic [31:0] exps[10] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF, 32'h80FF_7F01,
                              32'h0000_007F, 32'hFFFF_80FF, 32'h0000_0001, 32'h80FF_7F01, 32'h0000_7F01};
    for (int i = 0; i < 10; i++) begin
      drive_one(1, 0, 0, 3'b011, lts[i], 32'h80FF_7F01, alus[i], 32'hDEAD_0000, 5'd9, exps[i]);
      e = sb.pop_front();
      total += 4;
      if (write_data !== e.data) begin bad++; $display("FAIL load%0d_data got=%h exp=%h", i, write_data, e.data); end
      if (write_reg_out !== e.wr) begin bad++; $display("FAIL load%0d_reg got=%0d exp=%0d", i, write_reg_out, e.wr); end
      if (reg_write !== e.rw) begin bad++; $display("FAIL load%0d_rw got=%b exp=%b", i, reg_write, e.rw); end
      if (retired !== e.ret) begin bad++; $display("FAIL load%0d_retired got=%0d exp=%0d", i, retired, e.ret); end
    end
  endtask

  task automatic test_link_and_zero();
    logic [2:0]  ctl[6] = '{3'b101, 3'b111, 3'b100, 3'b001, 3'b000, 3'b001};
    logic [4:0]  wrs[6] = '{5'd0, 5'd4, 5'd6, 5'd0, 5'd7, 5'd0};
    logic        vs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exps[6] = '{32'h0040_0010, 32'h0040_0010, 32'h0040_0010, 32'h0000_0055, 32'h0000_0055, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drive_one(vs[i], 0, 0, ctl[i], 3'd3, 32'h80FF_7F01, 32'h0000_0055, 32'h0040_0010, wrs[i], exps[i]);
      e = sb.pop_front();
      total += 4;
      if (write_data !== e.data) begin bad++; $display("FAIL wb%0d_data got=%h exp=%h", i, write_data, e.data); end
      if (write_reg_out !== e.wr) begin bad++; $display("FAIL wb%0d_reg got=%0d exp=%0d", i, write_reg_out, e.wr); end
      if (reg_write !== e.rw) begin bad++; $display("FAIL wb%0d_rw got=%b exp=%b", i, reg_write, e.rw); end
      if (retired !== e.ret) begin bad++; $display("FAIL wb%0d_retired got=%0d exp=%0d", i, retired, e.ret); end
    end
  endtask

  task automatic test_stall_flush();
    // cycle 0 loads, 1-3 stall, 4 stall+flush, 5 flush alone, 6 normal load
    logic st[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic fl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive_one(1, st[i], fl[i], 3'b001, 3'd0, 32'h0, (i == 0) ? 32'h0000_A5A5 : 32'h0000_1111 * i,
                32'h0, (i == 0) ? 5'd12 : 5'(i), (i == 0) ? 32'h0000_A5A5 : 32'h0000_1111 * i);
      e = sb.pop_front();
      total += 4;
      if (write_data !== e.data) begin bad++; $display("FAIL sf%0d_data got=%h exp=%h", i, write_data, e.data); end
      if (write_reg_out !== e.wr) begin bad++; $display("FAIL sf%0d_reg got=%0d exp=%0d", i, write_reg_out, e.wr); end
      if (reg_write !== e.rw) begin bad++; $display("FAIL sf%0d_rw got=%b exp=%b", i, reg_write, e.rw); end
      if (retired !== e.ret) begin bad++; $display("FAIL sf%0d_retired got=%0d exp=%0d", i, retired, e.ret); end
    end
  endtask

  task automatic test_async_reset();
    drive_one(1, 0, 0, 3'b001, 3'd0, 32'h0, 32'h0000_0777, 32'h0, 5'd5, 32'h0000_0777);
    e = sb.pop_front();
    total += 1;
    if (reg_write !== e.rw) begin bad++; $display("FAIL ar_pre_rw got=%b exp=%b", reg_write, e.rw); end
    #1 rst_n = 1'b0;
    #1;
    held = '0; ret_model = 4'd0;
    total += 4;
    if (write_data !== 32'd0) begin bad++; $display("FAIL ar_data got=%h exp=0", write_data); end
    if (write_reg_out !== 5'd0) begin bad++; $display("FAIL ar_reg got=%0d exp=0", write_reg_out); end
    if (reg_write !== 1'b0) begin bad++; $display("FAIL ar_rw got=%b exp=0", reg_write); end
    if (retired !== 4'd0) begin bad++; $display("FAIL ar_retired got=%0d exp=0", retired); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Hold an instruction under stall, reset between edges, then keep stalling.
    drive_one(1, 0, 0, 3'b001, 3'd0, 32'h0, 32'h0000_0999, 32'h0, 5'd10, 32'h0000_0999);
    void'(sb.pop_front());
    drive_one(1, 1, 0, 3'b001, 3'd0, 32'h0, 32'h0000_0222, 32'h0, 5'd11, 32'h0000_0222);
    void'(sb.pop_front());
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    held = '0; ret_model = 4'd0;
    for (int i = 0; i < 2; i++) begin
      drive_one(1, (i == 0), 0, 3'b001, 3'd0, 32'h0, 32'h0000_0333, 32'h0, 5'd13, 32'h0000_0333);
      e = sb.pop_front();
      total += 4;
      if (write_data !== e.data) begin bad++; $display("FAIL rs%0d_data got=%h exp=%h", i, write_data, e.data); end
      if (write_reg_out !== e.wr) begin bad++; $display("FAIL rs%0d_reg got=%0d exp=%0d", i, write_reg_out, e.wr); end
      if (reg_write !== e.rw) begin bad++; $display("FAIL rs%0d_rw got=%b exp=%b", i, reg_write, e.rw); end
      if (retired !== e.ret) begin bad++; $display("FAIL rs%0d_retired got=%0d exp=%0d", i, retired, e.ret); end
    end
  endtask

  task automatic test_wrap();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    held = '0; ret_model = 4'd0;
    for (int i = 0; i < 16; i++) begin
      drive_one(1, 0, 0, 3'b001, 3'd0, 32'h0, 32'(i), 32'h0, 5'd2, 32'(i));
      e = sb.pop_front();
      total += 1;
      if (retired !== e.ret) begin bad++; $display("FAIL wrap%0d_retired got=%0d exp=%0d", i, retired, e.ret); end
    end
    total += 1;
    if (retired !== 4'd0) begin bad++; $display("FAIL wrap_final got=%0d exp=0", retired); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_rtype();
    test_loads();
    test_link_and_zero();
    test_stall_flush();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
